cva6_retire_buffer: RTL and testbench

//  Parametrised in-order retirement buffer for the CVA6 issue stage.
//  - Circular buffer of NR_ENTRIES slots: allocated in program order at issue, completed out of order by writeback ports.
//  - Retires up to NR_COMMIT_PORTS instructions per cycle, strictly in order.
//  - Generalises the fixed 2-port / 8-entry scoreboard configuration.
//  - Adds runtime flush, occupancy reporting and exception-aware multi-port commit.

---
 rtl/cva6_retire_buffer.sv | 158 +++++++++++++++
 tb/tb_cva6_retire_buffer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_retire_buffer.sv
// In-order retirement buffer: program-order allocation, out-of-order writeback,
// up to NR_COMMIT_PORTS in-order retirements per cycle with exception-aware port gating.
module cva6_retire_buffer #(
  parameter  int unsigned XLEN            = 32,
  parameter  int unsigned NR_ENTRIES      = 8,
  parameter  int unsigned NR_COMMIT_PORTS = 2,
  parameter  int unsigned NR_WB_PORTS     = 2,
  localparam int unsigned IDW             = $clog2(NR_ENTRIES)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [4:0]                      issue_rd_i,
  output logic [IDW-1:0]                  issue_id_o,
  input  logic [NR_WB_PORTS-1:0]          wb_valid_i,
  input  logic [NR_WB_PORTS*IDW-1:0]      wb_id_i,
  input  logic [NR_WB_PORTS*XLEN-1:0]     wb_result_i,
  input  logic [NR_WB_PORTS-1:0]          wb_ex_i,
  output logic [NR_COMMIT_PORTS-1:0]      commit_valid_o,
  output logic [NR_COMMIT_PORTS*5-1:0]    commit_rd_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0] commit_result_o,
  output logic [NR_COMMIT_PORTS-1:0]      commit_ex_o,
  input  logic [NR_COMMIT_PORTS-1:0]      commit_ack_i,
  output logic [IDW:0]                    usage_o
);

  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [NR_ENTRIES-1:0] done_q, done_d;
  logic [NR_ENTRIES-1:0] ex_q, ex_d;
  logic [4:0]            rd_q     [NR_ENTRIES];
  logic [XLEN-1:0]       result_q [NR_ENTRIES];
  logic [IDW-1:0]        head_q, head_d;
  logic [IDW-1:0]        tail_q, tail_d;
  logic [IDW:0]          count_q, count_d;

  logic                       issue_fire;
  logic [IDW:0]               n_retire;
  logic                       chain;
  logic                       run;
  logic [IDW-1:0]             cidx;
  logic [IDW-1:0]             wid;
  logic                       ack_nonprefix;

  assign issue_ready_o = (count_q < (IDW+1)'(NR_ENTRIES));
  assign issue_id_o    = tail_q;
  assign usage_o       = count_q;
  assign issue_fire    = issue_valid_i & issue_ready_o & ~flush_i;

  // A port is valid only if every lower port is valid and non-excepting;
  // an excepting entry may therefore only appear on port 0.
  always_comb begin
    commit_valid_o  = '0;
    commit_rd_o     = '0;
    commit_result_o = '0;
    commit_ex_o     = '0;
    chain           = 1'b1;
    cidx            = '0;
    for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
      cidx = head_q + IDW'(k);
      commit_valid_o[k] = chain & valid_q[cidx] & done_q[cidx] & ((k == 0) || !ex_q[cidx]);
      if (commit_valid_o[k]) begin
        commit_rd_o[k*5 +: 5]           = rd_q[cidx];
        commit_result_o[k*XLEN +: XLEN] = result_q[cidx];
        commit_ex_o[k]                  = ex_q[cidx];
      end
      chain = commit_valid_o[k] & ~ex_q[cidx];
    end
  end

  always_comb begin
    n_retire = '0;
    run      = 1'b1;
    for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
      run = run & commit_ack_i[k] & commit_valid_o[k];
      if (run) n_retire = n_retire + (IDW+1)'(1);
    end
  end

  assign ack_nonprefix = |(commit_ack_i & (commit_ack_i + NR_COMMIT_PORTS'(1)));

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    ex_d    = ex_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wid     = '0;
    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      ex_d    = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Ascending port order lets the highest port win on a shared id.
      for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
        wid = wb_id_i[p*IDW +: IDW];
        if (wb_valid_i[p] && valid_q[wid]) begin
          done_d[wid] = 1'b1;
          ex_d[wid]   = wb_ex_i[p];
        end
      end
      for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
        if (k < int'(n_retire)) begin
          valid_d[head_q + IDW'(k)] = 1'b0;
          done_d[head_q + IDW'(k)]  = 1'b0;
        end
      end
      if (issue_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        ex_d[tail_q]    = 1'b0;
        tail_d          = tail_q + IDW'(1);
      end
      head_d  = head_q + n_retire[IDW-1:0];
      count_d = count_q + (IDW+1)'(issue_fire) - n_retire;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      done_q  <= '0;
      ex_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      ex_q    <= ex_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; outputs are gated by the valid chain.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
      if (!flush_i && wb_valid_i[p] && valid_q[wb_id_i[p*IDW +: IDW]])
        result_q[wb_id_i[p*IDW +: IDW]] <= wb_result_i[p*XLEN +: XLEN];
    end
    if (issue_fire) begin
      rd_q[tail_q]     <= issue_rd_i;
      result_q[tail_q] <= '0;
    end
  end

  cover property (@(posedge clk_i) disable iff (!rst_ni) ack_nonprefix);

  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= (IDW+1)'(NR_ENTRIES));

endmodule

// File: tb/tb_cva6_retire_buffer.sv
// Randomised and directed bench for cva6_retire_buffer against a queue-based
// program-order model of the in-flight instruction window.
module tb_cva6_retire_buffer;
  localparam int XLEN = 32;
  localparam int N    = 8;
  localparam int P    = 2;
  localparam int W    = 2;
  localparam int IDW  = $clog2(N);

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [4:0]        issue_rd;
  logic [IDW-1:0]    issue_id;
  logic [W-1:0]      wb_valid;
  logic [W*IDW-1:0]  wb_id;
  logic [W*XLEN-1:0] wb_result;
  logic [W-1:0]      wb_ex;
  logic [P-1:0]      commit_valid;
  logic [P*5-1:0]    commit_rd;
  logic [P*XLEN-1:0] commit_result;
  logic [P-1:0]      commit_ex;
  logic [P-1:0]      commit_ack;
  logic [IDW:0]      usage;

  cva6_retire_buffer #(
    .XLEN(XLEN), .NR_ENTRIES(N), .NR_COMMIT_PORTS(P), .NR_WB_PORTS(W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_rd_i(issue_rd), .issue_id_o(issue_id),
    .wb_valid_i(wb_valid), .wb_id_i(wb_id), .wb_result_i(wb_result), .wb_ex_i(wb_ex),
    .commit_valid_o(commit_valid), .commit_rd_o(commit_rd),
    .commit_result_o(commit_result), .commit_ex_o(commit_ex),
    .commit_ack_i(commit_ack), .usage_o(usage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [4:0] rd;
    logic       done;
    logic       ex;
    logic [31:0] res;
  } ent_t;

  ent_t q[$];
  int   next_id = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  // Number of leading window entries that may be presented this cycle.
  function automatic int exp_m();
    int m = 0;
    for (int k = 0; k < P && k < q.size(); k++) begin
      if (!q[k].done) break;
      if (k > 0 && q[k].ex) break;
      m++;
      if (q[k].ex) break;
    end
    return m;
  endfunction

  int m_mdl, n_mdl, sz_mdl;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      next_id = 0;
    end else if (flush) begin
      q.delete();
      next_id = 0;
    end else begin
      sz_mdl = q.size();
      m_mdl  = exp_m();
      n_mdl  = 0;
      while (n_mdl < m_mdl && commit_ack[n_mdl]) n_mdl++;
      for (int p = 0; p < W; p++) begin
        if (wb_valid[p]) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].id == int'(wb_id[p*IDW +: IDW])) begin
              q[i].done = 1'b1;
              q[i].ex   = wb_ex[p];
              q[i].res  = wb_result[p*XLEN +: XLEN];
            end
          end
        end
      end
      repeat (n_mdl) q.delete(0);
      if (issue_valid && sz_mdl < N) begin
        q.push_back('{id: next_id, rd: issue_rd, done: 1'b0, ex: 1'b0, res: 32'h0});
        next_id = (next_id + 1) % N;
      end
    end
  end

  int m_mon;
  always @(negedge clk) begin
    if (rst_n) begin
      m_mon = exp_m();
      chk("ready", issue_ready, q.size() < N);
      chk("usage", usage, q.size());
      chk("issue_id", issue_id, next_id);
      chk("commit_valid", commit_valid, (1 << m_mon) - 1);
      for (int k = 0; k < m_mon; k++) begin
        chk("commit_rd", commit_rd[k*5 +: 5], q[k].rd);
        chk("commit_result", commit_result[k*XLEN +: XLEN], q[k].res);
        chk("commit_ex", commit_ex[k], q[k].ex);
      end
    end
  end

  task automatic clr();
    flush = 0; issue_valid = 0; issue_rd = '0;
    wb_valid = '0; wb_id = '0; wb_result = '0; wb_ex = '0; commit_ack = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic issue_n(input int cnt, input int rd0);
    for (int i = 0; i < cnt; i++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(rd0 + i);
      step();
    end
  endtask

  task automatic wb_one(input int port, input int id, input logic [31:0] res, input logic ex);
    wb_valid[port]               = 1'b1;
    wb_id[port*IDW +: IDW]       = IDW'(id);
    wb_result[port*XLEN +: XLEN] = res;
    wb_ex[port]                  = ex;
  endtask

  task automatic drain();
    int guard;
    int c;
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      c = 0;
      for (int i = 0; i < q.size() && c < W; i++) begin
        if (!q[i].done) begin
          wb_one(c, q[i].id, $urandom, 1'b0);
          c++;
        end
      end
      commit_ack = '1;
      step();
      guard++;
    end
    @(negedge clk);
    chk("drain_usage", usage, 0);
  endtask

  int pick;
  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", issue_ready, 1);
    chk("rst_usage", usage, 0);
    chk("rst_id", issue_id, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_cex", commit_ex, 0);
    chk("rst_crd", commit_rd, 0);
    chk("rst_cres", commit_result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Issue 8, write back all, retire two per cycle.
    issue_n(8, 1);
    @(negedge clk);
    chk("t1_full_usage", usage, 8);
    chk("t1_full_ready", issue_ready, 0);
    for (int i = 0; i < 8; i += 2) begin
      wb_one(0, i, 32'(i * 16), 1'b0);
      wb_one(1, i + 1, 32'((i + 1) * 16), 1'b0);
      step();
    end
    @(negedge clk);
    chk("t1_rd_pair", commit_rd, {5'd2, 5'd1});
    for (int i = 0; i < 4; i++) begin
      commit_ack = 2'b11;
      step();
    end
    @(negedge clk);
    chk("t1_empty", usage, 0);
    chk("t1_cvalid", commit_valid, 0);

    // Full buffer: ack and issue in the same cycle, issue must be refused.
    issue_n(8, 9);
    wb_one(0, q[0].id, 32'h55, 1'b0);
    step();
    issue_valid = 1'b1;
    issue_rd    = 5'd30;
    commit_ack  = 2'b01;
    step();
    @(negedge clk);
    chk("t2_usage", usage, 7);
    chk("t2_ready", issue_ready, 1);
    drain();

    // Reversed writeback order.
    issue_n(4, 10);
    for (int i = 3; i >= 1; i--) begin
      wb_one(0, q[i].id, 32'(100 + i), 1'b0);
      step();
      @(negedge clk);
      chk("t3_wait", commit_valid, 0);
    end
    wb_one(0, q[0].id, 32'd100, 1'b0);
    step();
    @(negedge clk);
    chk("t3_cvalid", commit_valid, 2'b11);
    chk("t3_rd", commit_rd, {5'd11, 5'd10});
    drain();

    // Exception on the second entry.
    issue_n(2, 20);
    wb_one(0, q[0].id, 32'hA, 1'b0);
    wb_one(1, q[1].id, 32'hB, 1'b1);
    step();
    @(negedge clk);
    chk("t4_cvalid0", commit_valid, 2'b01);
    chk("t4_ex0", commit_ex, 2'b00);
    commit_ack = 2'b01;
    step();
    @(negedge clk);
    chk("t4_cvalid1", commit_valid, 2'b01);
    chk("t4_ex1", commit_ex, 2'b01);
    commit_ack = 2'b01;
    step();

    // Flush with simultaneous issue, writeback and ack.
    issue_n(5, 3);
    wb_one(0, q[0].id, 32'h1, 1'b0);
    step();
    flush       = 1'b1;
    issue_valid = 1'b1;
    commit_ack  = 2'b11;
    wb_one(0, q[1].id, 32'h2, 1'b0);
    step();
    @(negedge clk);
    chk("t5_usage", usage, 0);
    chk("t5_id", issue_id, 0);
    chk("t5_cvalid", commit_valid, 0);

    // Random traffic including non-prefix acks, flushes and one mid-run reset.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      issue_valid = ($urandom_range(2) != 0);
      issue_rd    = 5'($urandom);
      for (int p = 0; p < W; p++) begin
        if ($urandom_range(9) < 7) begin
          if (q.size() > 0 && $urandom_range(3) != 0) pick = q[$urandom_range(q.size() - 1)].id;
          else pick = $urandom_range(N - 1);
          wb_one(p, pick, $urandom, ($urandom_range(7) == 0));
        end
      end
      case ($urandom_range(3))
        0: commit_ack = 2'b00;
        1: commit_ack = 2'b01;
        2: commit_ack = 2'b11;
        default: commit_ack = 2'b10;
      endcase
      flush = ($urandom_range(63) == 0);
      if (cyc == 700) begin
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    clr();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
